// File: rtl/clk_div_ratio_ctrl.sv
// ---------------------------------------------------------------------------
// clk_div_ratio_ctrl
//   Even-ratio clock divider whose ratio can be reprogrammed at runtime.
//   New ratios arrive over a valid/ready handshake and are checked first. An
//   accepted ratio waits until a falling edge of clk_out before it takes
//   effect, so clk_out never produces a runt or glitched phase. After the
//   switch, one full period runs at the new ratio before the next request is
//   accepted.
//
// Ports
//   clk        in   1      input clock, rising-edge logic
//   rst        in   1      asynchronous, active-low reset
//   cfg_valid  in   1      new ratio request valid
//   cfg_div    in   CNT_W  requested divide ratio
//   cfg_ready  out  1      request can be accepted this cycle
//   cfg_err    out  1      one-cycle pulse: the last transfer was illegal
//   clk_out    out  1      divided clock, 50% duty, registered
//   tick       out  1      one-cycle pulse in the first cycle clk_out is 1
//   busy       out  1      ratio change in progress
//   cur_div    out  CNT_W  ratio currently driving clk_out
// ---------------------------------------------------------------------------
module clk_div_ratio_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [CNT_W-1:0] cur_div
);

  if ((DEFAULT_DIV % 2) != 0 || DEFAULT_DIV < 2 ||
      DEFAULT_DIV > (2 ** CNT_W) - 2) begin : g_bad_default
    $error("clk_div_ratio_ctrl: DEFAULT_DIV must be even, >= 2 and fit CNT_W");
  end

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] pending;
  logic             phase_end;
  logic             fall;
  logic             xfer;
  logic             legal;

  // A ratio is usable only if it splits into two equal non-empty phases.
  function automatic logic is_legal(input logic [CNT_W-1:0] d);
    return (d[0] == 1'b0) && (d >= CNT_W'(2));
  endfunction

  assign half      = cur_div >> 1;
  assign phase_end = (cnt == half - CNT_W'(1));
  // Falling edge of clk_out happens on this clock edge.
  assign fall      = phase_end & clk_out;
  assign cfg_ready = (state == RUN);
  assign busy      = ~cfg_ready;
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = is_legal(cfg_div);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // The ratio swap waits for a falling edge; SETTLE then lets a complete
  // period of the new ratio go out before the next request is admitted.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (xfer && legal) state_nxt = PEND;
      PEND:    if (fall)          state_nxt = SETTLE;
      SETTLE:  if (fall)          state_nxt = RUN;
      default:                    state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      cfg_err <= 1'b0;
      cur_div <= CNT_W'(DEFAULT_DIV);
      pending <= '0;
    end else begin
      cfg_err <= xfer & ~legal;
      tick    <= phase_end & ~clk_out;
      if (phase_end) begin
        cnt     <= '0;
        clk_out <= ~clk_out;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Swapping at the fall with cnt already returning to 0 makes the
      // following low phase the first phase of the new ratio.
      if (state == PEND && fall) begin
        cur_div <= pending;
      end
      if (xfer && legal) begin
        pending <= cfg_div;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
module tb_clk_div_ratio_ctrl;

  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic [7:0] cfg_div;
  logic       cfg_ready;
  logic       cfg_err;
  logic       clk_out;
  logic       tick;
  logic       busy;
  logic [7:0] cur_div;

  int tests = 0;
  int fails = 0;

  clk_div_ratio_ctrl #(.CNT_W(8), .DEFAULT_DIV(4)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out),
    .tick(tick), .busy(busy), .cur_div(cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position k within the current period, where a period starts at
  // the falling edge. clk_out is high for the second half of the period.
  // phase: 0 idle, 1 waiting for a fall to switch, 2 running settle period.
  int   m_k     = 0;
  int   m_r     = 4;
  int   m_pend  = 0;
  int   m_phase = 0;
  logic m_err   = 1'b0;
  logic m_tick  = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_k = 0; m_r = 4; m_pend = 0; m_phase = 0; m_err = 1'b0; m_tick = 1'b0;
    end else begin
      automatic logic acc   = cfg_valid && (m_phase == 0);
      automatic logic ok    = (cfg_div % 2 == 0) && (cfg_div >= 2);
      automatic logic fellv;
      m_err = acc && !ok;
      m_k   = m_k + 1;
      fellv = (m_k == m_r);
      if (fellv) m_k = 0;
      m_tick = (m_k == m_r / 2);
      if (fellv) begin
        if (m_phase == 1) begin
          m_r = m_pend; m_phase = 2;
        end else if (m_phase == 2) begin
          m_phase = 0;
        end
      end
      if (acc && ok) begin
        m_pend = int'(cfg_div); m_phase = 1;
      end
    end
  end

  always @(negedge clk) begin
    automatic logic m_clk = (m_k >= m_r / 2);
    tests++;
    if (clk_out !== m_clk || tick !== m_tick || cfg_err !== m_err ||
        cfg_ready !== (m_phase == 0) || busy !== (m_phase != 0) ||
        cur_div !== 8'(m_r)) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t clk_out=%b/%b tick=%b/%b cfg_err=%b/%b ready=%b/%b busy=%b/%b cur_div=%0d/%0d (got/exp)",
               $time, clk_out, m_clk, tick, m_tick, cfg_err, m_err,
               cfg_ready, (m_phase == 0), busy, (m_phase != 0), cur_div, m_r);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Waits (at negedges) until tick is seen.
  task automatic wait_tick(output logic ok);
    int n = 0;
    ok = 1'b0;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      if (tick === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  // Cycles between two consecutive ticks; -1 on timeout.
  task automatic tick_gap(output int gap);
    logic ok;
    int   n = 0;
    gap = -1;
    wait_tick(ok);
    if (ok) begin
      while (n < 1000) begin
        @(negedge clk);
        n++;
        if (tick === 1'b1) begin gap = n; break; end
      end
    end
  endtask

  // Cycles clk_out stays high starting at a tick.
  task automatic high_width(output int w);
    logic ok;
    w = -1;
    wait_tick(ok);
    if (ok) begin
      w = 0;
      while (clk_out === 1'b1 && w < 1000) begin
        @(negedge clk);
        w++;
      end
    end
  endtask

  // Hold a request until it transfers; returns at the negedge after transfer.
  task automatic send(input int val, output int held);
    logic rdy;
    held = 0;
    cfg_valid = 1'b1;
    cfg_div   = 8'(val);
    do begin
      rdy = cfg_ready;
      @(negedge clk);
      held++;
    end while (!rdy && held < 3000);
    cfg_valid = 1'b0;
    if (!rdy) begin
      tests++; fails++;
      $display("FAIL send_timeout: got no transfer, expected transfer of %0d", val);
    end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (cfg_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (cfg_ready !== 1'b1) begin
      tests++; fails++;
      $display("FAIL idle_timeout: got busy, expected ready");
    end
  endtask

  initial begin
    int   g, h, n;
    logic ok;
    rst = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;

    // 1: reset state and default ratio
    @(negedge clk);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    check("rst_ready", int'(cfg_ready), 1);
    check("rst_cur_div", int'(cur_div), 4);
    @(negedge clk);
    rst = 1'b1;
    tick_gap(g);   check("t1_gap", g, 4);
    high_width(h); check("t1_high", h, 2);

    // 3: illegal ratios rejected
    send(7, n); check("t3_err7", int'(cfg_err), 1); check("t3_ready7", int'(cfg_ready), 1);
    send(0, n); check("t3_err0", int'(cfg_err), 1);
    send(1, n); check("t3_err1", int'(cfg_err), 1);
    @(negedge clk); check("t3_err_clear", int'(cfg_err), 0);
    tick_gap(g); check("t3_gap", g, 4);
    check("t3_cur_div", int'(cur_div), 4);

    // 2: switch to 10 starting right after a rise
    wait_tick(ok); check("t2_tick_seen", int'(ok), 1);
    cfg_valid = 1'b1; cfg_div = 8'd10;
    @(negedge clk);
    cfg_valid = 1'b0;
    check("t2_ready_low", int'(cfg_ready), 0);
    check("t2_still_high", int'(clk_out), 1);
    @(negedge clk);
    check("t2_fell", int'(clk_out), 0);
    check("t2_cur_div", int'(cur_div), 10);
    wait_idle(n); check("t2_settle_cycles", n, 10);
    tick_gap(g); check("t2_gap", g, 10);

    // 4: extremes of the ratio range
    send(2, n); wait_idle(n);
    tick_gap(g); check("t4_gap2", g, 2);
    send(254, n); wait_idle(n);
    tick_gap(g); check("t4_gap254", g, 254);
    high_width(h); check("t4_high254", h, 127);

    // 5: request held through PEND transfers on first RUN cycle
    send(4, n);
    send(8, n); check("t5_held_long", int'(n > 1), 1);
    wait_idle(n);
    check("t5_cur_div", int'(cur_div), 8);
    tick_gap(g); check("t5_gap", g, 8);

    // 6: reset while a change is pending with clk_out high
    send(10, n);
    n = 0;
    while (!(clk_out === 1'b1 && busy === 1'b1) && n < 100) begin
      @(negedge clk); n++;
    end
    check("t6_pend_high", int'(clk_out === 1'b1 && busy === 1'b1), 1);
    #2 rst = 1'b0;
    #1;
    check("t6_async_clk_out", int'(clk_out), 0);
    check("t6_async_cur_div", int'(cur_div), 4);
    check("t6_async_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    tick_gap(g); check("t6_gap", g, 4);
    tick_gap(g); check("t6_gap2", g, 4);
    check("t6_cur_div", int'(cur_div), 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
